agu_ar: RTL and testbench
=========================

// Module: agu_ar
// PURPOSE
//  Address generation unit that sits directly downstream of the address register file.
//  It reads one base AR, forms a 24-bit effective address (EA) from base plus sign-extended offset,
//  and optionally writes back an updated base (post-modify or pre-modify) through the file's write port.
//  EAs leave through a 2-entry skid buffer with valid/ready, feeding the memory stage.
// PARAMETERS
//  ADDR_W   24  address / AR width (matches SIZE_ADDR)
//  ARSEL_W  2   AR select width (matches HBIT_TGT_GP+1)
//  OFF_W    12  signed offset width, two's complement
// PORTS
//  iw_clk         in   1        clock, rising edge
//  iw_rst         in   1        reset, asynchronous, active-high
//  iw_valid       in   1        upstream request valid
//  ow_ready       out  1        unit can accept; registered, depends on buffer state only
//  iw_base_sel    in   ARSEL_W  base AR index
//  iw_offset      in   OFF_W    signed offset
//  iw_mode        in   2        00 indexed, 01 post-modify, 10 pre-modify, 11 absolute
//  ow_ar_rd_addr  out  ARSEL_W  AR read address (= iw_base_sel, combinational)
//  iw_ar_rd_data  in   ADDR_W   AR read data, combinational from register file
//  ow_ar_wr_en    out  1        AR writeback enable
//  ow_ar_wr_addr  out  ARSEL_W  AR writeback index (= iw_base_sel)
//  ow_ar_wr_data  out  ADDR_W   AR writeback value
//  ow_valid       out  1        EA valid to memory stage
//  iw_ready       in   1        memory stage accepts EA
//  ow_addr        out  ADDR_W   effective address
//  ow_wrap        out  1        EA or writeback sum wrapped modulo 2^ADDR_W
// BEHAVIOUR
//  Accept:
//  - Accept = iw_valid & ow_ready. Inputs are sampled only on an accept edge.
//  - SOFF = sign-extended offset.
//  Arithmetic (all sums modulo 2^ADDR_W):
//  - 00: EA = base+SOFF; no writeback.
//  - 01: EA = base; writeback base+SOFF.
//  - 10: EA = base+SOFF; writeback EA.
//  - 11: EA = zero-extended offset; no AR read dependency; no writeback.
//  Wrap flag:
//  - ow_wrap = 1 if the modified sum (EA for 00/10, writeback value for 01) crosses 0 or 2^ADDR_W-1.
//  - ow_wrap = 0 for mode 11.
//  Writeback:
//  - ow_ar_wr_en = accept & (mode==01 | mode==10); combinational.
//  - The register file commits at the accept edge, so the next request reading the same AR sees the new value.
//  - No bypass is needed.
//  Skid buffer, states EMPTY/ONE/TWO:
//  - ow_valid = (state!=EMPTY); ow_ready = (state!=TWO).
//  - ow_addr/ow_wrap come from the main register; skid holds the second entry.
//  - EMPTY + accept -> ONE, main <= new.
//  - ONE + accept & iw_ready -> ONE, main <= new.
//  - ONE + accept & !iw_ready -> TWO, skid <= new.
//  - ONE + iw_ready & !accept -> EMPTY.
//  - TWO + iw_ready -> ONE, main <= skid. No accept is possible in TWO.
//  - Outputs hold stable while ow_valid & !iw_ready; EA order is preserved.
//  Reset:
//  - state EMPTY, ow_valid 0, ow_addr 0, ow_wrap 0, skid 0.
//  - ow_ready and ow_ar_wr_en are forced 0 while iw_rst is high; ow_ready rises on the first edge after release.
//  - Reset mid-operation discards buffered EAs. Writebacks already committed are not undone.
//  - Latency: EA is valid the cycle after accept. Throughput is 1/cycle while iw_ready is high.
// TESTING
//  - AR1=0x001000, mode00, off=0xFFC (-4), iw_ready=1 -> next cycle ow_addr=0x000FFC, wr_en never high.
//  - AR2=0x000010, mode01 off=0x008, twice back-to-back -> EAs 0x000010 then 0x000018, AR2 ends 0x000020.
//  - AR0=0xFFFFFE, mode10 off=0x004 -> ow_addr=0x000002, ow_wrap=1, AR0 written 0x000002.
//  - iw_ready=0, three valid requests -> two accepted, ow_ready=0 on cycle 3.
//    Then iw_ready=1 -> EAs drain in order, ow_ready returns.
//  - mode11 off=0x800 -> ow_addr=0x000800 regardless of AR contents, ow_wrap=0, no writeback.
//  - Assert iw_rst with state TWO -> ow_valid=0 immediately, ow_ready=0 until release.
//    The first EA after release is the new request.

Source files
------------

// File: rtl/agu_ar.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// agu_ar -- address generation unit behind the address register (AR) file.
//
// Reads one base AR, forms a 24-bit effective address (EA) from base plus a
// sign-extended offset and, for the modify modes, writes an updated base back
// through the AR file write port. EAs leave through a 2-entry skid buffer so
// the upstream ready can be a plain flop.
//
// Ports
//   iw_clk, iw_rst   clock (rising edge), asynchronous active-high reset
//   iw_valid         upstream request valid
//   ow_ready         unit can accept (registered, buffer occupancy only)
//   iw_base_sel      base AR index
//   iw_offset        signed offset (two's complement)
//   iw_mode          00 indexed, 01 post-modify, 10 pre-modify, 11 absolute
//   ow_ar_rd_addr    AR read address, follows iw_base_sel
//   iw_ar_rd_data    AR read data, combinational from the AR file
//   ow_ar_wr_en      AR writeback enable (combinational, accept cycle only)
//   ow_ar_wr_addr    AR writeback index
//   ow_ar_wr_data    AR writeback value
//   ow_valid         EA valid to the memory stage
//   iw_ready         memory stage accepts the EA
//   ow_addr          effective address
//   ow_wrap          modified sum wrapped modulo 2^ADDR_W
//   ow_dbg_state     skid buffer state (0 EMPTY, 1 ONE, 2 TWO) for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. ow_valid/ow_addr/ow_wrap hold steady while ow_valid & !iw_ready.
// -----------------------------------------------------------------------------
module agu_ar #(
  parameter int ADDR_W  = 24,
  parameter int ARSEL_W = 2,
  parameter int OFF_W   = 12
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_valid,
  output logic               ow_ready,
  input  logic [ARSEL_W-1:0] iw_base_sel,
  input  logic [OFF_W-1:0]   iw_offset,
  input  logic [1:0]         iw_mode,
  output logic [ARSEL_W-1:0] ow_ar_rd_addr,
  input  logic [ADDR_W-1:0]  iw_ar_rd_data,
  output logic               ow_ar_wr_en,
  output logic [ARSEL_W-1:0] ow_ar_wr_addr,
  output logic [ADDR_W-1:0]  ow_ar_wr_data,
  output logic               ow_valid,
  input  logic               iw_ready,
  output logic [ADDR_W-1:0]  ow_addr,
  output logic               ow_wrap,
  output logic [1:0]         ow_dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_IDX  = 2'b00;
  localparam logic [1:0] MODE_POST = 2'b01;
  localparam logic [1:0] MODE_PRE  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  state_t              state_q, state_d;
  logic                ready_q;
  logic [ADDR_W-1:0]   main_addr_q, main_addr_d;
  logic                main_wrap_q, main_wrap_d;
  logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
  logic                skid_wrap_q, skid_wrap_d;

  logic                accept;
  logic [ADDR_W-1:0]   soff;
  logic [ADDR_W:0]     sum_full;
  logic [ADDR_W-1:0]   sum;
  logic                sum_wrap;
  logic [ADDR_W-1:0]   new_addr;
  logic                new_wrap;
  logic                new_wb;

  // ---------------------------------------------------------------------------
  // Address arithmetic
  // ---------------------------------------------------------------------------
  // The registered ready is masked by reset so nothing is accepted (and no
  // writeback fires) while reset is held.
  assign ow_ready = ready_q & ~iw_rst;
  assign accept   = iw_valid & ow_ready;

  assign soff     = {{(ADDR_W-OFF_W){iw_offset[OFF_W-1]}}, iw_offset};
  assign sum_full = {1'b0, iw_ar_rd_data} + {1'b0, soff};
  assign sum      = sum_full[ADDR_W-1:0];

  // Adding a positive offset wraps when it carries out; adding a negative
  // offset (encoded as 2^N - |off|) wraps exactly when it does NOT carry out.
  assign sum_wrap = sum_full[ADDR_W] ^ iw_offset[OFF_W-1];

  always_comb begin
    new_addr = sum;
    new_wrap = sum_wrap;
    new_wb   = 1'b0;
    case (iw_mode)
      MODE_IDX: begin
        new_addr = sum;
        new_wrap = sum_wrap;
        new_wb   = 1'b0;
      end
      MODE_POST: begin
        // EA is the old base; the wrap flag reports the writeback sum.
        new_addr = iw_ar_rd_data;
        new_wrap = sum_wrap;
        new_wb   = 1'b1;
      end
      MODE_PRE: begin
        new_addr = sum;
        new_wrap = sum_wrap;
        new_wb   = 1'b1;
      end
      MODE_ABS: begin
        new_addr = {{(ADDR_W-OFF_W){1'b0}}, iw_offset};
        new_wrap = 1'b0;
        new_wb   = 1'b0;
      end
      default: begin
        new_addr = sum;
        new_wrap = sum_wrap;
        new_wb   = 1'b0;
      end
    endcase
  end

  // The AR file commits on the accept edge, so a following request to the
  // same AR already reads the updated value without any bypass here.
  assign ow_ar_rd_addr = iw_base_sel;
  assign ow_ar_wr_addr = iw_base_sel;
  assign ow_ar_wr_data = sum;
  assign ow_ar_wr_en   = accept & new_wb;

  // ---------------------------------------------------------------------------
  // Skid buffer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q     <= S_EMPTY;
      ready_q     <= 1'b0;
      main_addr_q <= '0;
      main_wrap_q <= 1'b0;
      skid_addr_q <= '0;
      skid_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d != S_TWO);
      main_addr_q <= main_addr_d;
      main_wrap_q <= main_wrap_d;
      skid_addr_q <= skid_addr_d;
      skid_wrap_q <= skid_wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_addr_d = main_addr_q;
    main_wrap_d = main_wrap_q;
    skid_addr_d = skid_addr_q;
    skid_wrap_d = skid_wrap_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d     = S_ONE;
          main_addr_d = new_addr;
          main_wrap_d = new_wrap;
        end
      end
      S_ONE: begin
        if (accept && iw_ready) begin
          main_addr_d = new_addr;
          main_wrap_d = new_wrap;
        end else if (accept) begin
          // Main entry is stalled; park the new EA behind it.
          state_d     = S_TWO;
          skid_addr_d = new_addr;
          skid_wrap_d = new_wrap;
        end else if (iw_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // ready_q is low here, so accept cannot occur.
        if (iw_ready) begin
          state_d     = S_ONE;
          main_addr_d = skid_addr_q;
          main_wrap_d = skid_wrap_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  assign ow_valid     = (state_q != S_EMPTY);
  assign ow_addr      = main_addr_q;
  assign ow_wrap      = main_wrap_q;
  assign ow_dbg_state = state_q;

endmodule

// File: tb/tb_agu_ar.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_agu_ar -- directed and randomized bench for agu_ar.
// The bench owns the AR file (combinational read, write on the rising edge)
// and a separate reference copy of the ARs used to predict EAs, writebacks and
// buffer occupancy from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_agu_ar;

  logic        iw_clk = 1'b0;
  logic        iw_rst = 1'b1;
  logic        iw_valid = 1'b0;
  logic        ow_ready;
  logic [1:0]  iw_base_sel = '0;
  logic [11:0] iw_offset = '0;
  logic [1:0]  iw_mode = '0;
  logic [1:0]  ow_ar_rd_addr;
  logic [23:0] iw_ar_rd_data;
  logic        ow_ar_wr_en;
  logic [1:0]  ow_ar_wr_addr;
  logic [23:0] ow_ar_wr_data;
  logic        ow_valid;
  logic        iw_ready = 1'b0;
  logic [23:0] ow_addr;
  logic        ow_wrap;
  logic [1:0]  ow_dbg_state;

  agu_ar dut (
    .iw_clk        (iw_clk),
    .iw_rst        (iw_rst),
    .iw_valid      (iw_valid),
    .ow_ready      (ow_ready),
    .iw_base_sel   (iw_base_sel),
    .iw_offset     (iw_offset),
    .iw_mode       (iw_mode),
    .ow_ar_rd_addr (ow_ar_rd_addr),
    .iw_ar_rd_data (iw_ar_rd_data),
    .ow_ar_wr_en   (ow_ar_wr_en),
    .ow_ar_wr_addr (ow_ar_wr_addr),
    .ow_ar_wr_data (ow_ar_wr_data),
    .ow_valid      (ow_valid),
    .iw_ready      (iw_ready),
    .ow_addr       (ow_addr),
    .ow_wrap       (ow_wrap),
    .ow_dbg_state  (ow_dbg_state)
  );

  // clock / reset block
  always #5 iw_clk = ~iw_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // AR file environment: DUT writeback has priority over bench preloads.
  logic [23:0] rf [0:3] = '{24'h0, 24'h0, 24'h0, 24'h0};
  logic        pl_en  = 1'b0;
  logic [1:0]  pl_idx = '0;
  logic [23:0] pl_val = '0;

  assign iw_ar_rd_data = rf[ow_ar_rd_addr];

  always @(posedge iw_clk) begin
    if (ow_ar_wr_en) rf[ow_ar_wr_addr] <= ow_ar_wr_data;
    else if (pl_en)  rf[pl_idx] <= pl_val;
  end

  // scoreboard
  logic [24:0] exp_q[$];         // {wrap, addr}
  logic [23:0] m_ar [0:3] = '{24'h0, 24'h0, 24'h0, 24'h0};
  bit          ready_block = 1'b1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after a rising edge, check and update the
  // model at the falling edge, then advance past the next rising edge.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [11:0] off,
                       input logic [1:0] mode, input logic rdy);
    bit          exp_ready, acc, wb_en, wrap;
    int          base, soff, sum;
    logic [23:0] summ, ea;
    iw_valid    = v;
    iw_base_sel = sel;
    iw_offset   = off;
    iw_mode     = mode;
    iw_ready    = rdy;
    @(negedge iw_clk);
    exp_ready = !iw_rst && !ready_block && (exp_q.size() < 2);
    chk("ow_valid", {31'b0, ow_valid}, {31'b0, exp_q.size() > 0});
    chk("ow_ready", {31'b0, ow_ready}, {31'b0, exp_ready});
    chk("rd_addr", {30'b0, ow_ar_rd_addr}, {30'b0, sel});
    for (int i = 0; i < 4; i++) chk("ar_file", {8'b0, rf[i]}, {8'b0, m_ar[i]});
    if (exp_q.size() > 0) begin
      chk("ow_addr", {8'b0, ow_addr}, {8'b0, exp_q[0][23:0]});
      chk("ow_wrap", {31'b0, ow_wrap}, {31'b0, exp_q[0][24]});
      if (rdy) void'(exp_q.pop_front());
    end
    acc   = v && exp_ready;
    wb_en = acc && (mode == 2'b01 || mode == 2'b10);
    chk("wr_en", {31'b0, ow_ar_wr_en}, {31'b0, wb_en});
    if (acc) begin
      base = int'(m_ar[sel]);
      soff = $signed(off);
      sum  = base + soff;
      summ = sum[23:0];
      wrap = (mode != 2'b11) && (sum < 0 || sum > 32'h00FF_FFFF);
      case (mode)
        2'b00:   ea = summ;
        2'b01:   ea = m_ar[sel];
        2'b10:   ea = summ;
        default: ea = {12'b0, off};
      endcase
      if (wb_en) begin
        chk("wr_addr", {30'b0, ow_ar_wr_addr}, {30'b0, sel});
        chk("wr_data", {8'b0, ow_ar_wr_data}, {8'b0, summ});
        m_ar[sel] = summ;
      end
      exp_q.push_back({wrap, ea});
    end
    @(posedge iw_clk);
    ready_block = iw_rst;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 2'd0, 12'h0, 2'b00, rdy);
  endtask

  task automatic preload(input logic [1:0] idx, input logic [23:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    idle(1'b1);
    pl_en     = 1'b0;
    m_ar[idx] = val;
  endtask

  initial begin
    // reset: request modify with valid high; nothing may be accepted
    iw_valid = 1'b1;
    iw_mode  = 2'b01;
    repeat (3) @(posedge iw_clk);
    @(negedge iw_clk);
    chk("rst_valid", {31'b0, ow_valid}, 32'd0);
    chk("rst_ready", {31'b0, ow_ready}, 32'd0);
    chk("rst_addr", {8'b0, ow_addr}, 32'd0);
    chk("rst_wrap", {31'b0, ow_wrap}, 32'd0);
    chk("rst_wr_en", {31'b0, ow_ar_wr_en}, 32'd0);
    @(posedge iw_clk);
    #1;
    iw_rst = 1'b0;
    idle(1'b1);   // ready still low in this cycle, rises at the next edge

    // indexed with negative offset
    preload(2'd1, 24'h001000);
    cycle(1'b1, 2'd1, 12'hFFC, 2'b00, 1'b1);
    chk("t1_ea", {8'b0, ow_addr}, 32'h000FFC);
    chk("t1_wrap", {31'b0, ow_wrap}, 32'd0);
    idle(1'b1);

    // post-modify twice back to back
    preload(2'd2, 24'h000010);
    cycle(1'b1, 2'd2, 12'h008, 2'b01, 1'b1);
    chk("t2_ea0", {8'b0, ow_addr}, 32'h000010);
    cycle(1'b1, 2'd2, 12'h008, 2'b01, 1'b1);
    chk("t2_ea1", {8'b0, ow_addr}, 32'h000018);
    idle(1'b1);
    chk("t2_ar2", {8'b0, rf[2]}, 32'h000020);

    // pre-modify wrapping past the top
    preload(2'd0, 24'hFFFFFE);
    cycle(1'b1, 2'd0, 12'h004, 2'b10, 1'b1);
    chk("t3_ea", {8'b0, ow_addr}, 32'h000002);
    chk("t3_wrap", {31'b0, ow_wrap}, 32'd1);
    idle(1'b1);
    chk("t3_ar0", {8'b0, rf[0]}, 32'h000002);

    // stall: three requests, two accepted, then drain in order
    cycle(1'b1, 2'd1, 12'h010, 2'b00, 1'b0);
    cycle(1'b1, 2'd1, 12'h020, 2'b00, 1'b0);
    cycle(1'b1, 2'd1, 12'h030, 2'b00, 1'b0);
    chk("t4_full", {31'b0, ow_ready}, 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t4_ready_back", {31'b0, ow_ready}, 32'd1);

    // absolute mode
    preload(2'd3, 24'hABCDEF);
    cycle(1'b1, 2'd3, 12'h800, 2'b11, 1'b1);
    chk("t5_ea", {8'b0, ow_addr}, 32'h000800);
    chk("t5_wrap", {31'b0, ow_wrap}, 32'd0);
    idle(1'b1);

    // reset while two EAs are buffered
    cycle(1'b1, 2'd2, 12'h004, 2'b00, 1'b0);
    cycle(1'b1, 2'd2, 12'h008, 2'b00, 1'b0);
    iw_rst = 1'b1;
    #1;
    chk("t6_valid", {31'b0, ow_valid}, 32'd0);
    chk("t6_ready", {31'b0, ow_ready}, 32'd0);
    exp_q.delete();
    cycle(1'b1, 2'd2, 12'h004, 2'b01, 1'b1);
    iw_rst = 1'b0;
    cycle(1'b1, 2'd2, 12'h004, 2'b01, 1'b1);   // ready not yet back
    cycle(1'b1, 2'd0, 12'h123, 2'b11, 1'b1);
    chk("t6_first_ea", {8'b0, ow_addr}, 32'h000123);
    idle(1'b1);

    // randomized traffic with boundary-heavy bases
    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       preload(2'($urandom_range(0, 3)), 24'hFFFFFF - 24'($urandom_range(0, 15)));
          1:       preload(2'($urandom_range(0, 3)), 24'($urandom_range(0, 15)));
          default: preload(2'($urandom_range(0, 3)), 24'($urandom));
        endcase
      end
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
    end
    repeat (3) idle(1'b1);
    chk("drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
